cga_sequencer_arb: RTL
======================

Name: cga_sequencer_arb

Overview:
- Parametrised successor to the CGA display sequencer: a free-running slot counter that times VRAM fetches, CRTC clocking, character ROM reads and display pipeline loads.
- Adds three things the current sequencer lacks:
  - a registered ISA access arbiter with a request/acknowledge handshake and a wait output for IOCHRDY;
  - mode changes deferred to the period boundary, so they cannot glitch;
  - a deferrable phase-resync input.
- Sits between the ISA bus interface, the VRAM controller and the CRTC/pixel pipeline.

Parameters:
PERIOD, 32, counter period in clk cycles; must be even and >= 16; HALF = PERIOD/2
CNT_W, 5, counter width; must equal clog2(PERIOD)
DISP_DLY_STD, 4, slot of the disp_pipeline strobe in normal modes
DISP_DLY_ALT, 7, slot of the disp_pipeline strobe when tandy_16_gfx is active
ISA_OP_LEN, 3, cycles per granted ISA operation
WIN_LO, 5, first in-half slot in which an ISA grant may start

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
hres_mode  in  1  80-column / high-rate mode request
tandy_16_gfx  in  1  Tandy 16-colour graphics delay request
phase_rst  in  1  one-cycle pulse that forces the counter to 0
isa_req  in  1  ISA access request; level, held until isa_ack
clk_seq  out  CNT_W  current counter value
lclk  out  1  once-per-period strobe
hclk  out  1  twice-per-period strobe
crtc_clk  out  1  CRTC character clock
vram_read  out  1  VRAM owned by the display
vram_read_a0  out  1  VRAM address bit 0 select
vram_read_char  out  1  latch character byte
vram_read_att  out  1  latch attribute byte
charrom_read  out  1  character ROM read
disp_pipeline  out  1  load the display pipeline
isa_op_enable  out  1  VRAM owned by the ISA operation
isa_ack  out  1  one-cycle pulse on the last ISA cycle
isa_wait  out  1  request pending and not yet granted

Behaviour:

Counter:
- cnt runs 0..PERIOD-1 and wraps to 0.
- slot = cnt mod HALF; h = (cnt >= HALF).
- clk_seq = cnt.

Mode registers:
- hres_r and alt_r capture hres_mode and tandy_16_gfx only when cnt == PERIOD-1.
- All decodes below use hres_r and alt_r, never the raw inputs.
- en2 = (h == 0) || hres_r.

Strobes (combinational from registered state; all forced 0 while reset_n is low):
- lclk = (cnt == 0).
- hclk = (slot == 0).
- crtc_clk = (cnt == 0) || (hres_r && cnt == HALF).
- vram_read = slot in 1..3.
- vram_read_a0 = (slot == 2).
- vram_read_char = (slot == 2) && en2.
- vram_read_att = charrom_read = (slot == 3) && en2.
- disp_pipeline = (slot == (alt_r ? DISP_DLY_ALT : DISP_DLY_STD)) && en2.

ISA arbiter FSM, states IDLE / BUSY / DONE:
- IDLE -> BUSY when isa_req = 1 and WIN_LO <= slot <= HALF-2-ISA_OP_LEN+1. The operation must end by slot HALF-2, which leaves a guard of at least 2 cycles before the next slot 1. ocnt is loaded with 0.
- BUSY:
  - isa_op_enable = 1 and ocnt increments each cycle.
  - When ocnt == ISA_OP_LEN-1, isa_ack = 1 for that cycle and the FSM moves to DONE.
- DONE: lasts one cycle; isa_req is ignored (the requester drops it after ack); then IDLE.
- isa_wait = isa_req && (state != BUSY) && !(state == DONE).
- isa_op_enable and vram_read must never be 1 in the same cycle.

Phase resync:
- A phase_rst pulse sets rs_pend.
- When rs_pend = 1 and state != BUSY, the next cnt is 0 and rs_pend is cleared.
- An ISA operation is never truncated by a resync.
- phase_rst arriving while rs_pend is already 1 is absorbed (no double reset).

Reset:
- cnt = 0, state = IDLE, rs_pend = 0, hres_r = 0, alt_r = 0, ocnt = 0.
- All outputs 0, including clk_seq.
- On the first cycle after release, cnt = 0 and lclk = hclk = crtc_clk = 1.
- reset_n low during BUSY aborts the operation with no isa_ack.

Simultaneous events:
- A request arriving in the last legal start slot is granted.
- A request arriving one slot later waits for the next half's window.
- Mode capture and phase_rst in the same cycle: the capture occurs, then the counter resets.

Test Plan:
1. Defaults, hres_mode = 0, no ISA: after reset, crtc_clk at cnt 0 only; vram_read_char at cnt 2 only; vram_read at 1-3 and 17-19; disp_pipeline at 4; period 32 cycles.
2. hres_mode raised at cnt 10: no change until cnt wraps; from the next period, crtc_clk at 0 and 16, vram_read_char at 2 and 18, disp_pipeline at 4 and 20. With tandy_16_gfx also set, disp_pipeline at 7 and 23.
3. isa_req raised at cnt 1: isa_wait = 1 for cnts 1-4; isa_op_enable at cnts 5-7; isa_ack at cnt 7; isa_wait = 0 from cnt 5.
4. isa_req raised at cnt 13 (last legal start is 12): wait until cnt 21; op at 21-23; ack at 23; no overlap with vram_read at any time.
5. phase_rst at cnt 6 during a BUSY op (5-7): op completes; cnt = 0 on the cycle after cnt 7; a second phase_rst at cnt 7 is absorbed.
6. reset_n low at cnt 6 mid-op: no isa_ack; all outputs 0 during reset; after release, cnt = 0, FSM IDLE, and a still-asserted isa_req is granted at cnt 5.

Source files
------------

// File: rtl/cga_sequencer_arb.sv
// cga_sequencer_arb
// Free-running display slot sequencer for the CGA pipeline. A PERIOD-cycle
// counter is split into two halves of HALF slots. The low slots of each half
// belong to the display (VRAM fetch, character ROM, pipeline load). A window
// later in each half is handed out to single ISA operations. Mode inputs only
// take effect at the period boundary. A phase resync is held off until any
// running ISA operation has finished.
//
// ISA handshake: isa_req is a level that the requester holds until it sees
// isa_ack. The arbiter grants only when the operation will start in slot
// WIN_LO..HALF-2-ISA_OP_LEN+1 of the coming cycle. It then drives
// isa_op_enable for ISA_OP_LEN cycles and pulses isa_ack on the last one.
// It spends one DONE cycle, ignoring isa_req, so the requester can drop it.
// isa_wait (IOCHRDY hold-off) is high while a request is pending and idle.
module cga_sequencer_arb #(
   parameter int PERIOD       = 32,
   parameter int CNT_W        = 5,
   parameter int DISP_DLY_STD = 4,
   parameter int DISP_DLY_ALT = 7,
   parameter int ISA_OP_LEN   = 3,
   parameter int WIN_LO       = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hres_mode,
   input  logic             tandy_16_gfx,
   input  logic             phase_rst,
   input  logic             isa_req,
   output logic [CNT_W-1:0] clk_seq,
   output logic             lclk,
   output logic             hclk,
   output logic             crtc_clk,
   output logic             vram_read,
   output logic             vram_read_a0,
   output logic             vram_read_char,
   output logic             vram_read_att,
   output logic             charrom_read,
   output logic             disp_pipeline,
   output logic             isa_op_enable,
   output logic             isa_ack,
   output logic             isa_wait
);

   localparam int HALF   = PERIOD / 2;
   // Last slot in which an operation may start and still end by slot HALF-2.
   localparam int WIN_HI = HALF - 2 - ISA_OP_LEN + 1;
   localparam int OCNT_W = (ISA_OP_LEN > 1) ? $clog2(ISA_OP_LEN) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]  HALF_V     = CNT_W'(HALF);
   localparam logic [CNT_W-1:0]  SLOT_1     = CNT_W'(1);
   localparam logic [CNT_W-1:0]  SLOT_2     = CNT_W'(2);
   localparam logic [CNT_W-1:0]  SLOT_3     = CNT_W'(3);
   localparam logic [CNT_W-1:0]  DISP_STD_V = CNT_W'(DISP_DLY_STD);
   localparam logic [CNT_W-1:0]  DISP_ALT_V = CNT_W'(DISP_DLY_ALT);
   localparam logic [CNT_W-1:0]  WIN_LO_V   = CNT_W'(WIN_LO);
   localparam logic [CNT_W-1:0]  WIN_HI_V   = CNT_W'(WIN_HI);
   localparam logic [OCNT_W-1:0] OCNT_LAST  = OCNT_W'(ISA_OP_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   // Registered state
   logic [CNT_W-1:0]  cnt;
   logic              hres_r;
   logic              alt_r;
   logic              rs_pend;
   arb_state_t        state;
   logic [OCNT_W-1:0] ocnt;

   // Derived combinational terms
   logic [CNT_W-1:0] slot;
   logic             h;
   logic             en2;
   logic [CNT_W-1:0] disp_slot;
   logic             op_continues;
   logic             resync_take;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] slot_nxt;
   logic             grant;

   // Position of a counter value inside its half-period.
   function automatic logic [CNT_W-1:0] slot_of(input logic [CNT_W-1:0] c);
      return (c >= HALF_V) ? (c - HALF_V) : c;
   endfunction

   // Slot decode and half-period enable from the current counter and modes
   always_comb begin
      slot      = slot_of(cnt);
      h         = (cnt >= HALF_V);
      en2       = !h || hres_r;
      disp_slot = alt_r ? DISP_ALT_V : DISP_STD_V;
   end

   // Next counter value. A pending resync waits while an ISA operation
   // still has cycles left after this one. The final operation cycle may be
   // followed directly by slot 0. Grants look at the slot of the next cycle,
   // so the first operation cycle lands exactly on a legal start slot.
   always_comb begin
      op_continues = (state == ST_BUSY) && (ocnt != OCNT_LAST);
      resync_take  = rs_pend && !op_continues;
      if (resync_take) begin
         cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
      slot_nxt = slot_of(cnt_nxt);
      grant    = (state == ST_IDLE) && isa_req &&
                 (slot_nxt >= WIN_LO_V) && (slot_nxt <= WIN_HI_V);
   end

   // Slot counter: free-running, wraps at PERIOD-1, jumps to 0 on resync
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   // Resync request latch. A pulse arriving while one is already pending,
   // or in the cycle the pending one is taken, is absorbed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rs_pend <= 1'b0;
      end else if (resync_take) begin
         rs_pend <= 1'b0;
      end else if (phase_rst) begin
         rs_pend <= 1'b1;
      end
   end

   // Mode capture on the last cycle of the period so decodes never glitch
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hres_r <= 1'b0;
         alt_r  <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         hres_r <= hres_mode;
         alt_r  <= tandy_16_gfx;
      end
   end

   // ISA arbiter: IDLE waits for a request and a legal start slot, BUSY
   // counts out the operation, DONE is a one-cycle settle for the requester
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         ocnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state <= ST_BUSY;
                  ocnt  <= '0;
               end
            end
            ST_BUSY: begin
               if (ocnt == OCNT_LAST) begin
                  state <= ST_DONE;
                  ocnt  <= '0;
               end else begin
                  ocnt <= ocnt + OCNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               ocnt  <= '0;
            end
         endcase
      end
   end

   // Output decode: pure functions of registered state, all held low in reset
   always_comb begin
      clk_seq        = '0;
      lclk           = 1'b0;
      hclk           = 1'b0;
      crtc_clk       = 1'b0;
      vram_read      = 1'b0;
      vram_read_a0   = 1'b0;
      vram_read_char = 1'b0;
      vram_read_att  = 1'b0;
      charrom_read   = 1'b0;
      disp_pipeline  = 1'b0;
      isa_op_enable  = 1'b0;
      isa_ack        = 1'b0;
      isa_wait       = 1'b0;
      if (reset_n) begin
         clk_seq        = cnt;
         lclk           = (cnt == '0);
         hclk           = (slot == '0);
         crtc_clk       = (cnt == '0) || (hres_r && (cnt == HALF_V));
         vram_read      = (slot >= SLOT_1) && (slot <= SLOT_3);
         vram_read_a0   = (slot == SLOT_2);
         vram_read_char = (slot == SLOT_2) && en2;
         vram_read_att  = (slot == SLOT_3) && en2;
         charrom_read   = (slot == SLOT_3) && en2;
         disp_pipeline  = (slot == disp_slot) && en2;
         isa_op_enable  = (state == ST_BUSY);
         isa_ack        = (state == ST_BUSY) && (ocnt == OCNT_LAST);
         isa_wait       = isa_req && (state == ST_IDLE);
      end
   end

endmodule
